// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch/PC unit: PCSRC selects, fetch FSM states,
// and the branch opcodes that the next-PC logic inspects.
package fetch_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  localparam logic [5:0]  OP_BEQ = 6'd4;
  localparam logic [5:0]  OP_BNE = 6'd5;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection and PC write enable for the fetch unit.
// With BRANCH_NE_EN defined, a BNE held in IR inverts the branch condition.
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [1:0]        pc_src,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              zero,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_next
);

`ifdef BRANCH_NE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  logic is_bne_s;
  logic cond_take_s;

  always_comb begin
    is_bne_s    = (opcode_of(ir) == OP_BNE);
    cond_take_s = zero ^ (BNE_EN & is_bne_s);
    pc_we       = pc_write | (pc_write_cond & cond_take_s);
    case (pc_src)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[DATA_W-1:28], ir[25:0], 2'b00};
      // HOLD keeps the PC even when a write is requested
      default:      pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and variable-latency fetch FSM of the
// multicycle MIPS core. Optional macro BRANCH_NE_EN enables BNE branch sense.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IRWRITE,
  input  logic              PCWRITE,
  input  logic              PCWRITECOND,
  input  logic              ZERO,
  input  logic [1:0]        PCSRC,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_READY,
  output logic              MEM_REQ,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [5:0]        OPCODE,
  output logic              FETCH_BUSY,
  output logic              FETCH_DONE,
  output logic              FETCH_ERR
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              pc_we_s;
  logic [DATA_W-1:0] pc_next_s;

  pc_next_logic #(.DATA_W(DATA_W)) u_pc_next (
    .pc           (pc_q),
    .ir           (ir_q),
    .alu_result   (ALU_RESULT),
    .alu_out      (ALU_OUT),
    .pc_src       (PCSRC),
    .pc_write     (PCWRITE),
    .pc_write_cond(PCWRITECOND),
    .zero         (ZERO),
    .pc_we        (pc_we_s),
    .pc_next      (pc_next_s)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    pc_d    = pc_we_s ? pc_next_s : pc_q;
    case (state_q)
      IDLE: begin
        // a request coinciding with the completion pulse is dropped
        if (IRWRITE && !done_q) begin
          state_d = WAIT;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = pc_q;
          cnt_d   = 8'd0;
        end else begin
          req_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      WAIT: begin
        if (MEM_READY || (cnt_q == TO_LAST)) begin
          ir_d    = MEM_READY ? MEM_RDATA : DATA_W'(NOP);
          err_d   = err_q | ~MEM_READY;
          done_d  = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          addr_d  = '0;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        addr_d  = '0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign MEM_REQ    = req_q;
  assign MEM_ADDR   = addr_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign OPCODE     = opcode_of(ir_q);
  assign FETCH_BUSY = busy_q;
  assign FETCH_DONE = done_q;
  assign FETCH_ERR  = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: behavioural fetch/PC model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_pc_unit;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IRWRITE, PCWRITE, PCWRITECOND, ZERO, MEM_READY;
  logic [1:0]  PCSRC;
  logic [31:0] ALU_RESULT, ALU_OUT, MEM_RDATA;
  logic        MEM_REQ, FETCH_BUSY, FETCH_DONE, FETCH_ERR;
  logic [31:0] MEM_ADDR, PC, IR;
  logic [5:0]  OPCODE;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .IRWRITE(IRWRITE), .PCWRITE(PCWRITE),
    .PCWRITECOND(PCWRITECOND), .ZERO(ZERO), .PCSRC(PCSRC),
    .ALU_RESULT(ALU_RESULT), .ALU_OUT(ALU_OUT), .MEM_RDATA(MEM_RDATA),
    .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .PC(PC),
    .IR(IR), .OPCODE(OPCODE), .FETCH_BUSY(FETCH_BUSY), .FETCH_DONE(FETCH_DONE),
    .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fetch is "in flight" with an address and a wait count
  logic [31:0] m_pc, m_ir, m_faddr, m_npc;
  logic        m_err, m_done, m_done_nxt, m_fetching, m_take;
  int          m_waited;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_pc = 32'h0; m_ir = 32'h0; m_faddr = 32'h0; m_err = 1'b0;
      m_done = 1'b0; m_fetching = 1'b0; m_waited = 0;
    end else begin
      m_take = ZERO;
`ifdef BRANCH_NE_EN
      if (m_ir[31:26] == 6'd5) m_take = !ZERO;
`endif
      if ((PCWRITE || (PCWRITECOND && m_take)) && PCSRC != 2'b11) begin
        if (PCSRC == 2'b00)      m_npc = ALU_RESULT;
        else if (PCSRC == 2'b01) m_npc = ALU_OUT;
        else                     m_npc = {m_pc[31:28], m_ir[25:0], 2'b00};
      end else begin
        m_npc = m_pc;
      end
      m_done_nxt = 1'b0;
      if (m_fetching) begin
        if (MEM_READY) begin
          m_ir = MEM_RDATA; m_done_nxt = 1'b1; m_fetching = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_ir = 32'h0; m_err = 1'b1; m_done_nxt = 1'b1; m_fetching = 1'b0;
          end
        end
      end else if (IRWRITE && !m_done) begin
        m_fetching = 1'b1; m_faddr = m_pc; m_waited = 0;
      end
      m_done = m_done_nxt;
      m_pc   = m_npc;
    end
  end

  always @(negedge CLK) begin
    chk("cyc_pc", PC, m_pc);
    chk("cyc_ir", IR, m_ir);
    chk("cyc_opcode", {26'd0, OPCODE}, {26'd0, m_ir[31:26]});
    chk("cyc_req", {31'd0, MEM_REQ}, {31'd0, m_fetching});
    chk("cyc_busy", {31'd0, FETCH_BUSY}, {31'd0, m_fetching});
    chk("cyc_addr", MEM_ADDR, m_fetching ? m_faddr : 32'h0);
    chk("cyc_done", {31'd0, FETCH_DONE}, {31'd0, m_done});
    chk("cyc_err", {31'd0, FETCH_ERR}, {31'd0, m_err});
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  int busy_n;
  int n;

  initial begin
    RESET = 1'b1; IRWRITE = 1'b0; PCWRITE = 1'b0; PCWRITECOND = 1'b0; ZERO = 1'b0;
    MEM_READY = 1'b0; PCSRC = 2'b00; ALU_RESULT = 32'h0; ALU_OUT = 32'h0; MEM_RDATA = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_err", {31'd0, FETCH_ERR}, 32'd0);
    RESET = 1'b0;

    // minimum-latency fetch
    MEM_RDATA = 32'h8C01_0004; IRWRITE = 1'b1; MEM_READY = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    chk("t1_req", {31'd0, MEM_REQ}, 32'd1);
    chk("t1_addr", MEM_ADDR, 32'h0);
    chk("t1_done_early", {31'd0, FETCH_DONE}, 32'd0);
    cyc();
    chk("t1_done", {31'd0, FETCH_DONE}, 32'd1);
    chk("t1_ir", IR, 32'h8C01_0004);
    chk("t1_opcode", {26'd0, OPCODE}, 32'd35);
    IRWRITE = 1'b1; MEM_READY = 1'b0;
    cyc();
    chk("t1_ignore_on_done", {31'd0, FETCH_BUSY}, 32'd0);
    chk("t1_done_pulse", {31'd0, FETCH_DONE}, 32'd0);

    // fetch with concurrent PC write and delayed memory
    MEM_RDATA = 32'h0800_0010; PCWRITE = 1'b1; PCSRC = 2'b00; ALU_RESULT = 32'h4;
    cyc();
    PCWRITE = 1'b0;
    busy_n = FETCH_BUSY ? 1 : 0;
    chk("t2_pc", PC, 32'h4);
    chk("t2_addr", MEM_ADDR, 32'h0);
    repeat (3) begin
      cyc();
      if (FETCH_BUSY) busy_n++;
      chk("t2_addr_hold", MEM_ADDR, 32'h0);
    end
    IRWRITE = 1'b0; MEM_READY = 1'b1;
    cyc();
    MEM_READY = 1'b0;
    chk("t2_done", {31'd0, FETCH_DONE}, 32'd1);
    chk("t2_busy_cycles", busy_n, 32'd4);
    chk("t2_ir", IR, 32'h0800_0010);

    // jump and hold
    PCWRITE = 1'b1; ALU_RESULT = 32'h20;
    cyc();
    chk("t3_pc_alu", PC, 32'h20);
    PCSRC = 2'b10;
    cyc();
    chk("t3_pc_jump", PC, 32'h40);
    PCSRC = 2'b11; ALU_RESULT = 32'h99;
    cyc();
    chk("t3_pc_hold", PC, 32'h40);
    PCWRITE = 1'b0;

    // conditional branch on ZERO
    PCWRITECOND = 1'b1; PCSRC = 2'b01; ALU_OUT = 32'h100; ZERO = 1'b0;
    cyc();
    chk("t4_beq_not_taken", PC, 32'h40);
    ZERO = 1'b1;
    cyc();
    chk("t4_beq_taken", PC, 32'h100);
    PCWRITECOND = 1'b0; ZERO = 1'b0;

    // BNE held in IR
    MEM_RDATA = 32'h1420_0003; IRWRITE = 1'b1; MEM_READY = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    cyc();
    MEM_READY = 1'b0;
    chk("t4_bne_opcode", {26'd0, OPCODE}, 32'd5);
    PCWRITECOND = 1'b1; ALU_OUT = 32'h200; ZERO = 1'b0;
    cyc();
`ifdef BRANCH_NE_EN
    chk("t4_bne_zero0", PC, 32'h200);
`else
    chk("t4_bne_zero0", PC, 32'h100);
`endif
    ZERO = 1'b1; ALU_OUT = 32'h300;
    cyc();
`ifdef BRANCH_NE_EN
    chk("t4_bne_zero1", PC, 32'h200);
`else
    chk("t4_bne_zero1", PC, 32'h300);
`endif
    PCWRITECOND = 1'b0; ZERO = 1'b0;

    // ready on the very cycle the timeout would fire
    MEM_RDATA = 32'h2001_0007; IRWRITE = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    repeat (14) cyc();
    chk("t5_edge_busy", {31'd0, FETCH_BUSY}, 32'd1);
    MEM_READY = 1'b1;
    cyc();
    MEM_READY = 1'b0;
    chk("t5_edge_done", {31'd0, FETCH_DONE}, 32'd1);
    chk("t5_edge_ir", IR, 32'h2001_0007);
    chk("t5_edge_noerr", {31'd0, FETCH_ERR}, 32'd0);
    cyc();

    // timeout
    MEM_RDATA = 32'hDEAD_BEEF; IRWRITE = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    busy_n = 0; n = 0;
    while (!FETCH_DONE && n < 40) begin
      if (FETCH_BUSY) busy_n++;
      cyc();
      n++;
    end
    if (n >= 40) chk("t5_timeout_bound", 32'd0, 32'd1);
    chk("t5_wait_cycles", busy_n, TIMEOUT);
    chk("t5_ir_nop", IR, 32'h0);
    chk("t5_err", {31'd0, FETCH_ERR}, 32'd1);

    // sticky error across a good fetch
    cyc();
    MEM_RDATA = 32'h8C02_0008; IRWRITE = 1'b1; MEM_READY = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    cyc();
    MEM_READY = 1'b0;
    chk("t5_ok_ir", IR, 32'h8C02_0008);
    chk("t5_err_sticky", {31'd0, FETCH_ERR}, 32'd1);

    // reset in the middle of a wait
    cyc();
    IRWRITE = 1'b1;
    cyc();
    IRWRITE = 1'b0;
    cyc();
    #2 RESET = 1'b1;
    #1;
    chk("t6_req_async", {31'd0, MEM_REQ}, 32'd0);
    chk("t6_pc", PC, 32'h0);
    chk("t6_ir", IR, 32'h0);
    chk("t6_err", {31'd0, FETCH_ERR}, 32'd0);
    MEM_READY = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (2) begin
      cyc();
      chk("t6_late_done", {31'd0, FETCH_DONE}, 32'd0);
      chk("t6_late_ir", IR, 32'h0);
    end
    MEM_READY = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
